// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the RV32M multi-cycle sequencer: funct3 op encoding, FSM states,
// divider iteration count and operand-signedness helpers.
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } muldiv_state_t;

    localparam int DIV_ITERS = 32;

    function automatic logic op_a_signed(input muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // MULHSU treats rs2 as unsigned; the low word of MUL is sign-agnostic anyway.
    function automatic logic op_b_signed(input muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes. The first iteration runs in the
// start cycle; done flags the cycle whose step produces the final quotient/remainder.
module muldiv_div_core
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_ITERS);

    logic [CNT_W-1:0] cnt;
    logic             active;
    logic [XLEN-1:0]  rem_q, quo_q, dsr_q;
    logic [XLEN-1:0]  rem_in, quo_in, dsr_in;
    logic [XLEN-1:0]  rem_step, quo_step;
    logic [XLEN:0]    trial;

    always_comb begin
        rem_in = start ? '0       : rem_q;
        quo_in = start ? dividend : quo_q;
        dsr_in = start ? divisor  : dsr_q;
        // One extra bit so a borrow shows up as the sign of the trial subtraction.
        trial  = {rem_in, quo_in[XLEN-1]} - {1'b0, dsr_in};
        if (trial[XLEN]) begin
            rem_step = {rem_in[XLEN-2:0], quo_in[XLEN-1]};
            quo_step = {quo_in[XLEN-2:0], 1'b0};
        end else begin
            rem_step = trial[XLEN-1:0];
            quo_step = {quo_in[XLEN-2:0], 1'b1};
        end
    end

    assign done      = active && !start && (cnt == '0);
    assign quotient  = quo_step;
    assign remainder = rem_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= CNT_W'(DIV_ITERS - 2);
        end else if (active) begin
            if (cnt == '0) active <= 1'b0;
            else           cnt    <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start || active) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
        end
        if (start) dsr_q <= divisor;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: stalls execute while a multiply or divide runs, then
// strobes the result for one cycle. Optional build macro MULDIV_EARLY_OUT_EN.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            start_e_i,
    input  muldiv_op_t      op_e_i,
    input  logic [XLEN-1:0] src_a_e_i,
    input  logic [XLEN-1:0] src_b_e_i,
    input  logic            flush_e_i,
    output logic            stall_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output logic            busy_o
);

    localparam int CNT_W = 3;

    muldiv_state_t     state, state_next;
    muldiv_op_t        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [CNT_W-1:0]  cnt;
    logic              div_setup;
    logic [XLEN-1:0]   result_q, result_d;
    logic              result_en, load;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [2*XLEN-1:0] prod_mag, prod;
    logic [XLEN-1:0]   mul_result;

    logic              is_rem, div_short;
    logic [XLEN-1:0]   spec_q, spec_r;
    logic              core_start, core_done;
    logic [XLEN-1:0]   core_quo, core_rem, div_result;

    // Operands are held for the whole op, so signs and magnitudes are derived from them.
    always_comb begin
        a_neg    = op_a_signed(op_q) & a_q[XLEN-1];
        b_neg    = op_b_signed(op_q) & b_q[XLEN-1];
        abs_a    = a_neg ? -a_q : a_q;
        abs_b    = b_neg ? -b_q : b_q;
        prod_mag = (2*XLEN)'(abs_a) * (2*XLEN)'(abs_b);
        prod     = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
        mul_result = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        is_rem    = op_q[1];
        div_short = 1'b0;
        spec_q    = '0;
        spec_r    = a_q;
        if (b_q == '0) begin
            div_short = 1'b1;
            spec_q    = '1;
        end else if (op_a_signed(op_q) && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1)) begin
            div_short = 1'b1;
            spec_q    = a_q;
            spec_r    = '0;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (abs_a < abs_b) begin
            div_short = 1'b1;
        end
`endif
        if (is_rem) div_result = a_neg ? -core_rem : core_rem;
        else        div_result = (a_neg ^ b_neg) ? -core_quo : core_quo;
    end

    muldiv_div_core #(
        .XLEN(XLEN)
    ) u_div_core (
        .clk      (clk_i),
        .rst_n    (reset_ni),
        .start    (core_start),
        .dividend (abs_a),
        .divisor  (abs_b),
        .done     (core_done),
        .quotient (core_quo),
        .remainder(core_rem)
    );

    always_comb begin
        state_next     = state;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        load           = 1'b0;
        core_start     = 1'b0;
        result_en      = 1'b0;
        result_d       = result_q;
        case (state)
            S_IDLE: begin
                // Gated by reset so the held instruction is not stalled while in reset.
                if (start_e_i && !flush_e_i && reset_ni) begin
                    stall_o    = 1'b1;
                    load       = 1'b1;
                    state_next = op_e_i[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                stall_o = 1'b1;
                if (flush_e_i) begin
                    state_next = S_IDLE;
                end else if (cnt == '0) begin
                    state_next = S_DONE;
                    result_en  = 1'b1;
                    result_d   = mul_result;
                end
            end
            S_DIV: begin
                stall_o = 1'b1;
                if (flush_e_i) begin
                    state_next = S_IDLE;
                end else if (div_setup) begin
                    if (div_short) begin
                        state_next = S_DONE;
                        result_en  = 1'b1;
                        result_d   = is_rem ? spec_r : spec_q;
                    end else begin
                        core_start = 1'b1;
                    end
                end else if (core_done) begin
                    state_next = S_DONE;
                    result_en  = 1'b1;
                    result_d   = div_result;
                end
            end
            S_DONE: begin
                result_valid_o = 1'b1;
                state_next     = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= S_IDLE;
            cnt       <= '0;
            div_setup <= 1'b0;
            result_q  <= '0;
        end else begin
            state <= state_next;
            if (load)                           cnt <= CNT_W'(MUL_LATENCY - 1);
            else if (state == S_MUL && cnt != '0) cnt <= cnt - 1'b1;
            if (load)                div_setup <= 1'b1;
            else if (state == S_DIV) div_setup <= 1'b0;
            if (result_en) result_q <= result_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load) begin
            op_q <= op_e_i;
            a_q  <= src_a_e_i;
            b_q  <= src_b_e_i;
        end
    end

    assign busy_o   = (state != S_IDLE);
    assign result_o = result_q;

endmodule
